// File: rtl/rs232_mem_pkg.sv
// Shared definitions for the RS232 memory command sequencer and its macro.
// Provides default bus widths, the command/acknowledge byte values and the
// sequencer state encoding.
package rs232_mem_pkg;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 8;

  localparam logic [7:0] OP_WR    = 8'h57;  // 'W'
  localparam logic [7:0] OP_RD    = 8'h52;  // 'R'
  localparam logic [7:0] ACK_BYTE = 8'h4B;  // 'K'

  typedef enum logic [3:0] {
    IDLE,
    ADDR_H,
    ADDR_L,
    LEN,
    WR_DATA,
    WR_ACK,
    RD_ISSUE,
    RD_WAIT,
    RD_SEND
  } state_e;

endpackage

// File: rtl/rs232_mem_tx_hold.sv
// One-entry output register for the UART TX path.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   load_i     - capture data_i and raise valid_o
//   data_i     - byte to present
//   ready_i    - downstream accepts when valid_o && ready_i
//   valid_o    - byte pending; held until accepted
//   data_o     - pending byte; stable while valid_o is high
module rs232_mem_tx_hold
  import rs232_mem_pkg::*;
#(
  parameter int unsigned DATA_W = rs232_mem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  // The sequencer only loads while the register is empty, so a load never
  // overwrites a byte that is still waiting for the transmitter.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/rs232_mem_ctrl.sv
// Command sequencer between the UART byte stream and the memory macro.
// Parses "op, addr_hi, addr_lo, len[, data...]" commands, performs write or
// read bursts on the macro and returns an ack byte or the read data.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   rx_data, rx_valid    - received byte strobe
//   tx_data, tx_valid,   - outgoing byte with valid/ready handshake
//   tx_ready
//   mem_addr, mem_write, - macro address, write strobe, write data
//   mem_wdata
//   mem_rdata            - macro read data, RD_LAT cycles after the address
//   busy                 - sequencer not in IDLE
//   cmd_err              - pulse on an unknown opcode
//   rx_overrun           - pulse when a byte arrives that cannot be taken
module rs232_mem_ctrl
  import rs232_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = rs232_mem_pkg::ADDR_W,
  parameter int unsigned DATA_W   = rs232_mem_pkg::DATA_W,
  parameter int unsigned RD_LAT   = 1,
  parameter logic [7:0]  OP_WR    = rs232_mem_pkg::OP_WR,
  parameter logic [7:0]  OP_RD    = rs232_mem_pkg::OP_RD,
  parameter logic [7:0]  ACK_BYTE = rs232_mem_pkg::ACK_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              cmd_err,
  output logic              rx_overrun
);

  localparam int unsigned CNT_W = DATA_W + 1;  // len=0 encodes 256
  localparam int unsigned LAT_W = 2;           // RD_LAT is 1..3

  state_e            state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [DATA_W-1:0] addr_hi_q, addr_hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_write_q, mem_write_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q;
  logic              cmd_err_q, cmd_err_d;
  logic              rx_overrun_q, rx_overrun_d;

  logic              tx_load_c;
  logic [DATA_W-1:0] tx_load_data_c;
  logic              tx_fire_c;
  logic              last_c;
  logic              accept_c;
  logic              op_wr_c;
  logic              op_rd_c;

  assign tx_fire_c = tx_valid && tx_ready;
  assign last_c    = (count_q == CNT_W'(1));
  assign op_wr_c   = (rx_data == DATA_W'(OP_WR));
  assign op_rd_c   = (rx_data == DATA_W'(OP_RD));
  assign accept_c  = (state_q == IDLE) || (state_q == ADDR_H) || (state_q == ADDR_L) ||
                     (state_q == LEN)  || (state_q == WR_DATA);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (rx_valid && (op_wr_c || op_rd_c)) state_d = ADDR_H;
      ADDR_H:   if (rx_valid) state_d = ADDR_L;
      ADDR_L:   if (rx_valid) state_d = LEN;
      LEN:      if (rx_valid) state_d = is_wr_q ? WR_DATA : RD_ISSUE;
      WR_DATA:  if (rx_valid && last_c) state_d = WR_ACK;
      WR_ACK:   if (tx_fire_c) state_d = IDLE;
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT:  if (lat_q == LAT_W'(RD_LAT)) state_d = RD_SEND;
      RD_SEND:  if (tx_fire_c) state_d = last_c ? IDLE : RD_ISSUE;
      default:  state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    is_wr_d        = is_wr_q;
    addr_hi_d      = addr_hi_q;
    addr_d         = addr_q;
    count_d        = count_q;
    lat_d          = lat_q;
    mem_addr_d     = mem_addr_q;
    mem_write_d    = 1'b0;
    mem_wdata_d    = mem_wdata_q;
    cmd_err_d      = 1'b0;
    tx_load_c      = 1'b0;
    tx_load_data_c = mem_rdata;
    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (op_wr_c)      is_wr_d   = 1'b1;
          else if (op_rd_c) is_wr_d   = 1'b0;
          else              cmd_err_d = 1'b1;
        end
      end
      ADDR_H: if (rx_valid) addr_hi_d = rx_data;
      // Upper unused bits of addr_hi fall away in the cast
      ADDR_L: if (rx_valid) addr_d = ADDR_W'({addr_hi_q, rx_data});
      LEN: begin
        if (rx_valid) count_d = (rx_data == '0) ? {1'b1, {DATA_W{1'b0}}} : {1'b0, rx_data};
      end
      WR_DATA: begin
        if (rx_valid) begin
          mem_addr_d  = addr_q;
          mem_wdata_d = rx_data;
          mem_write_d = 1'b1;
          addr_d      = addr_q + ADDR_W'(1);
          count_d     = count_q - CNT_W'(1);
        end
      end
      // First WR_ACK cycle overlaps the final write; the ack follows it
      WR_ACK: begin
        if (!tx_valid) begin
          tx_load_c      = 1'b1;
          tx_load_data_c = DATA_W'(ACK_BYTE);
        end
      end
      RD_ISSUE: begin
        mem_addr_d = addr_q;
        lat_d      = '0;
      end
      // Data for the address registered at issue is valid RD_LAT cycles later
      RD_WAIT: begin
        if (lat_q == LAT_W'(RD_LAT)) tx_load_c = 1'b1;
        else                         lat_d     = lat_q + LAT_W'(1);
      end
      RD_SEND: begin
        if (tx_fire_c) begin
          addr_d  = addr_q + ADDR_W'(1);
          count_d = count_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
    rx_overrun_d = rx_valid && !accept_c;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      is_wr_q      <= 1'b0;
      addr_hi_q    <= '0;
      addr_q       <= '0;
      count_q      <= '0;
      lat_q        <= '0;
      mem_addr_q   <= '0;
      mem_write_q  <= 1'b0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      cmd_err_q    <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      is_wr_q      <= is_wr_d;
      addr_hi_q    <= addr_hi_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      lat_q        <= lat_d;
      mem_addr_q   <= mem_addr_d;
      mem_write_q  <= mem_write_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= (state_d != IDLE);
      cmd_err_q    <= cmd_err_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  rs232_mem_tx_hold #(
    .DATA_W (DATA_W)
  ) u_tx_hold (
    .clk     (clk),
    .rst     (rst),
    .load_i  (tx_load_c),
    .data_i  (tx_load_data_c),
    .ready_i (tx_ready),
    .valid_o (tx_valid),
    .data_o  (tx_data)
  );

  assign mem_addr   = mem_addr_q;
  assign mem_write  = mem_write_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign cmd_err    = cmd_err_q;
  assign rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_rs232_mem_ctrl.sv
// Bench for rs232_mem_ctrl: two instances (RD_LAT=1 and RD_LAT=3) share the
// same byte stream; each has its own memory model. Expected tx bytes and
// memory writes are queued by the stimulus and checked by one monitor.
`timescale 1ns/1ps
module tb_rs232_mem_ctrl;

  localparam int NI    = 2;
  localparam int AW    = 14;
  localparam int MEM_N = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst      = 1'b1;
  logic [7:0]    rx_data  = 8'h00;
  logic          rx_valid = 1'b0;
  logic          tx_ready = 1'b1;

  logic [7:0]    tx_data    [NI];
  logic          tx_valid   [NI];
  logic [AW-1:0] mem_addr   [NI];
  logic          mem_write  [NI];
  logic [7:0]    mem_wdata  [NI];
  logic [7:0]    mem_rdata  [NI];
  logic          busy       [NI];
  logic          cmd_err    [NI];
  logic          rx_overrun [NI];

  logic [7:0] mem   [NI][MEM_N] = '{default: '0};
  logic [7:0] rpipe [NI][3]     = '{default: '0};

  // Stimulus-side state
  logic [7:0]    ref_mem [MEM_N] = '{default: '0};
  logic [7:0]    exp_tx [$];
  logic [AW+7:0] exp_wr [$];
  logic [7:0]    wbuf [$];
  int            exp_err   = 0;
  int            exp_ovr   = 0;
  int            timeouts  = 0;
  int            zero_req  = 0;
  bit            final_req = 1'b0;
  bit            mon_en    = 1'b0;

  // Monitor-side state
  int            n_checks   = 0;
  int            n_fail     = 0;
  int            zero_seen  = 0;
  bit            final_done = 1'b0;
  int            tx_idx  [NI] = '{0, 0};
  int            wr_idx  [NI] = '{0, 0};
  int            err_cnt [NI] = '{0, 0};
  int            ovr_cnt [NI] = '{0, 0};
  logic          stall_prev [NI] = '{1'b0, 1'b0};
  logic [7:0]    prev_data  [NI];
  logic [AW-1:0] prev_addr  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 1 : 3;
    rs232_mem_ctrl #(
      .RD_LAT (LAT)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .tx_data    (tx_data[g]),
      .tx_valid   (tx_valid[g]),
      .tx_ready   (tx_ready),
      .mem_addr   (mem_addr[g]),
      .mem_write  (mem_write[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_rdata  (mem_rdata[g]),
      .busy       (busy[g]),
      .cmd_err    (cmd_err[g]),
      .rx_overrun (rx_overrun[g])
    );
    assign mem_rdata[g] = rpipe[g][LAT-1];
  end

  // Memory macro models: synchronous write, LAT-stage read pipeline
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (mem_write[g]) mem[g][mem_addr[g]] <= mem_wdata[g];
      rpipe[g][0] <= mem[g][mem_addr[g]];
      rpipe[g][1] <= rpipe[g][0];
      rpipe[g][2] <= rpipe[g][1];
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: samples between the input drive edge and the next active edge
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      for (int g = 0; g < NI; g++) begin
        if (tx_valid[g] && tx_ready) begin
          if (tx_idx[g] < exp_tx.size())
            chk($sformatf("tx_byte%0d inst%0d", tx_idx[g], g), 32'(tx_data[g]), 32'(exp_tx[tx_idx[g]]));
          else begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_tx inst%0d: got %0h expected none", g, tx_data[g]);
          end
          tx_idx[g]++;
        end
        if (stall_prev[g])
          chk($sformatf("stall_hold inst%0d", g),
              32'({tx_valid[g], tx_data[g], mem_addr[g]}), 32'({1'b1, prev_data[g], prev_addr[g]}));
        stall_prev[g] = tx_valid[g] && !tx_ready;
        prev_data[g]  = tx_data[g];
        prev_addr[g]  = mem_addr[g];
        if (mem_write[g]) begin
          if (wr_idx[g] < exp_wr.size())
            chk($sformatf("mem_write%0d inst%0d", wr_idx[g], g),
                32'({mem_addr[g], mem_wdata[g]}), 32'(exp_wr[wr_idx[g]]));
          else begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write inst%0d: got addr %0h data %0h expected none",
                     g, mem_addr[g], mem_wdata[g]);
          end
          wr_idx[g]++;
        end
        if (cmd_err[g])    err_cnt[g]++;
        if (rx_overrun[g]) ovr_cnt[g]++;
      end
      if (zero_req != zero_seen) begin
        zero_seen = zero_req;
        for (int g = 0; g < NI; g++)
          chk($sformatf("reset_outputs inst%0d", g),
              32'({mem_addr[g], mem_write[g], mem_wdata[g], tx_data[g], tx_valid[g],
                   busy[g], cmd_err[g], rx_overrun[g]}), 32'(0));
      end
      if (final_req && !final_done) begin
        for (int g = 0; g < NI; g++) begin
          chk($sformatf("tx_count inst%0d", g), 32'(tx_idx[g]), 32'(exp_tx.size()));
          chk($sformatf("wr_count inst%0d", g), 32'(wr_idx[g]), 32'(exp_wr.size()));
          chk($sformatf("cmd_err_count inst%0d", g), 32'(err_cnt[g]), 32'(exp_err));
          chk($sformatf("overrun_count inst%0d", g), 32'(ovr_cnt[g]), 32'(exp_ovr));
        end
        chk("idle_timeouts", 32'(timeouts), 32'(0));
        final_done = 1'b1;
      end
    end
  end

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic rx_idle();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [AW-1:0] addr, input logic [7:0] len);
    rx_byte(op);
    rx_byte({2'b00, addr[AW-1:8]});
    rx_byte(addr[7:0]);
    rx_byte(len);
  endtask

  // Write the bytes in wbuf starting at addr; expects the writes and an ack
  task automatic issue_write(input logic [AW-1:0] addr);
    logic [AW-1:0] a;
    a = addr;
    foreach (wbuf[i]) begin
      exp_wr.push_back({a, wbuf[i]});
      ref_mem[a] = wbuf[i];
      a = a + 14'd1;
    end
    exp_tx.push_back(8'h4B);
    send_hdr(8'h57, addr, 8'(wbuf.size()));
    foreach (wbuf[i]) rx_byte(wbuf[i]);
    rx_idle();
  endtask

  task automatic issue_read(input logic [AW-1:0] addr, input logic [7:0] len);
    logic [AW-1:0] a;
    int n;
    a = addr;
    n = (len == 8'h00) ? 256 : int'(len);
    for (int i = 0; i < n; i++) begin
      exp_tx.push_back(ref_mem[a]);
      a = a + 14'd1;
    end
    send_hdr(8'h52, addr, len);
    rx_idle();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < 5000 && (busy[0] || busy[1] || tx_valid[0] || tx_valid[1]));
    if (n >= 5000) begin
      timeouts++;
      $display("FAIL wait_idle: got busy=%b%b tx_valid=%b%b expected all 0",
               busy[0], busy[1], tx_valid[0], tx_valid[1]);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    zero_req++;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single write and readback
    wbuf = '{8'hA5};
    issue_write(14'h0010);
    wait_idle();
    issue_read(14'h0010, 8'h01);
    wait_idle();

    // Back-to-back burst across the top of the address space
    wbuf = '{8'h11, 8'h22, 8'h33};
    issue_write(14'h3FFE);
    wait_idle();
    issue_read(14'h3FFE, 8'h03);
    wait_idle();

    // len=0 means 256 bytes
    wbuf.delete();
    for (int i = 0; i < 256; i++) wbuf.push_back(8'(i));
    issue_write(14'h0100);
    wait_idle();
    issue_read(14'h0100, 8'h00);
    wait_idle();

    // Unknown opcode in IDLE
    rx_byte(8'h00);
    rx_idle();
    exp_err++;
    repeat (3) @(negedge clk);

    // Backpressure with a byte arriving during RD_SEND
    tx_ready = 1'b0;
    issue_read(14'h3FFE, 8'h04);
    repeat (10) @(negedge clk);
    rx_byte(8'h52);
    rx_idle();
    exp_ovr++;
    repeat (10) @(negedge clk);
    tx_ready = 1'b1;
    wait_idle();

    // Reset after two of four write data bytes
    exp_wr.push_back({14'h0020, 8'hD1});
    exp_wr.push_back({14'h0021, 8'hD2});
    ref_mem[14'h0020] = 8'hD1;
    ref_mem[14'h0021] = 8'hD2;
    send_hdr(8'h57, 14'h0020, 8'h04);
    rx_byte(8'hD1);
    rx_byte(8'hD2);
    @(negedge clk);
    rx_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    zero_req++;
    @(negedge clk);
    rst = 1'b0;
    rx_byte(8'h33);
    rx_idle();
    exp_err++;
    repeat (3) @(negedge clk);
    issue_read(14'h0020, 8'h04);
    wait_idle();

    final_req = 1'b1;
    for (int i = 0; i < 20 && !final_done; i++) @(negedge clk);
    if (!final_done) begin
      $display("FAIL final_check: got not reached expected reached");
      $fatal(1, "monitor did not complete");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs232_mem_ctrl.md
Name: rs232_mem_ctrl

Overview:
Command sequencer between the RS232 byte receiver/transmitter and rs232_mem_macro. It parses a byte-oriented command stream (write burst / read burst) from the UART RX path and drives the macro's address, write-strobe and write-data lines. It returns read data or an acknowledge byte to the UART TX path through a valid/ready handshake. It is the only master of the memory macro.

Parameters:
ADDR_W, 14, memory address width (matches macro mem_addr)
DATA_W, 8, data width (matches macro data bus and UART byte)
RD_LAT, 1, cycles from address presented (mem_write=0) to valid mem_rdata; legal range 1..3
OP_WR, 8'h57, write opcode ('W')
OP_RD, 8'h52, read opcode ('R')
ACK_BYTE, 8'h4B, byte returned after a completed write burst ('K')

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous and active-high
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe: rx_data is valid
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data valid; held until accepted
tx_ready  in  1  transmitter accepts tx_data when tx_valid&&tx_ready
mem_addr  out  ADDR_W  macro address
mem_write  out  1  macro write strobe (1=write, 0=read)
mem_wdata  out  8  macro write data (to mem_data_in)
mem_rdata  in  8  macro read data (from mem_data_out)
busy  out  1  high in any state other than IDLE
cmd_err  out  1  one-cycle pulse on an unknown opcode
rx_overrun  out  1  one-cycle pulse when rx_valid arrives while the block cannot accept a byte

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE. All outputs 0: mem_addr, mem_write, mem_wdata, tx_data, tx_valid, busy, cmd_err, rx_overrun. Internal addr/count cleared. Reset mid-burst aborts immediately. No partial write completes after the reset edge. A pending tx byte is dropped.
- Command format: opcode, addr_hi, addr_lo, len, then len data bytes for a write only.
  - Start address = {addr_hi,addr_lo}[ADDR_W-1:0]. Upper unused bits of addr_hi are ignored.
  - len is 8 bits. len=0 means 256.
- IDLE: on rx_valid:
  - OP_WR or OP_RD: latch opcode, go to ADDR_H.
  - Any other byte: pulse cmd_err, stay in IDLE.
- ADDR_H, ADDR_L, LEN: each state advances on rx_valid.
  - After LEN: a write goes to WR_DATA; a read goes to RD_ISSUE.
- WR_DATA: on each rx_valid:
  - In the next cycle, mem_addr=addr, mem_wdata=rx_data, mem_write=1 for exactly one cycle.
  - addr increments modulo 2^ADDR_W (0x3FFF -> 0x0000); count decrements.
  - After the last byte's write cycle, go to WR_ACK.
  - mem_write is 0 in every other cycle and every other state.
- WR_ACK: tx_data=ACK_BYTE, tx_valid=1. On the handshake, go to IDLE.
- RD_ISSUE: drive mem_addr=addr with mem_write=0 for one cycle, then go to RD_WAIT.
- RD_WAIT: wait until RD_LAT cycles have elapsed since issue. Capture mem_rdata into tx_data, then go to RD_SEND.
- RD_SEND: tx_valid=1, tx_data held stable.
  - On handshake: addr increments with wrap, count decrements.
  - count becomes 0 -> IDLE; otherwise -> RD_ISSUE.
  - tx_valid may fall and rise on consecutive cycles.
- Byte acceptance:
  - A byte is accepted in IDLE, ADDR_H, ADDR_L, LEN and WR_DATA.
  - rx_valid in any other state (RD_*, WR_ACK): byte dropped, rx_overrun pulses, state unchanged.
  - Back-to-back rx_valid on consecutive cycles in WR_DATA must be sustained: one write per cycle, pipelined.
- tx_valid/tx_data must not change while tx_valid=1 && tx_ready=0.
- mem_addr holds its last value when idle.
- No inter-byte timeout. A stalled command waits until more bytes arrive or until reset.

Decomposition:
- Shared package rs232_mem_pkg:
  - FSM state encoding: IDLE, ADDR_H, ADDR_L, LEN, WR_DATA, WR_ACK, RD_ISSUE, RD_WAIT, RD_SEND.
  - OP_WR, OP_RD, ACK_BYTE constants.
  - ADDR_W/DATA_W defaults, reused by the macro and the top level.
- Sub-module rs232_mem_tx_hold: one-entry output register implementing the valid/ready hold rule, shared by the ack path and the read path. The FSM and address/count datapath stay in rs232_mem_ctrl.

Test Plan:
- Single write. rx 57,00,10,01,A5 -> one cycle with mem_write=1, mem_addr=0x0010, mem_wdata=A5, then tx 4B. Readback 52,00,10,01 -> tx A5.
- Burst with wrap. Write 57,3F,FE,03,11,22,33 sent on consecutive cycles -> writes to 3FFE, 3FFF, 0000, each mem_write pulse one cycle wide. Read 52,3F,FE,03 -> tx 11,22,33.
- len=0. Write 256 bytes (value = index) at 0x0100. Read back 52,01,00,00 -> 256 bytes returned, 00..FF in order, then busy=0.
- Backpressure. Hold tx_ready=0 for 20 cycles during a 4-byte read -> tx_valid stays 1, tx_data stable, no extra mem reads issued. Release -> remaining bytes in order. Repeat with RD_LAT=3.
- Errors. rx 00 in IDLE -> cmd_err pulses once, state stays IDLE. rx_valid during RD_SEND -> rx_overrun pulses, read data unaffected.
- Reset mid-burst. Assert rst after 2 of 4 write data bytes -> all outputs 0 next cycle, third byte is never written. A fresh 52,... command then works normally.
